// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions used by the data-memory readback engine.
// Provides data/address widths, the dump word-count width and the
// dump controller state encoding.
package rv32i_pkg;

   localparam int DPW       = 32;
   localparam int ADW       = 32;
   localparam int DUMP_CNTW = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } dump_state_e;

   // Force a byte address onto a word boundary.
   function automatic logic [ADW-1:0] dump_align(input logic [ADW-1:0] addr);
      return {addr[ADW-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/dmem_dump_fifo.sv
// Output buffer for dmem_dump: synchronous FIFO carrying {last, data}
// with an occupancy count. Storage is cleared by the asynchronous reset
// so the stream outputs read as zero straight out of reset.
module dmem_dump_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 33
) (
   input  logic                       clk,
   input  logic                       arst,
   input  logic                       push_i,
   input  logic [W-1:0]               push_data_i,
   input  logic                       pop_i,
   output logic [W-1:0]               pop_data_o,
   output logic                       valid_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] ZERO_C  = '0;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push_s;
   logic          do_pop_s;

   assign do_push_s  = push_i && (count_q != DEPTH_C);
   assign do_pop_s   = pop_i && (count_q != ZERO_C);
   assign pop_data_o = mem_q[rd_ptr_q];
   assign valid_o    = (count_q != ZERO_C);
   assign count_o    = count_q;

   // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + (AW)'(1);
         end
         if (do_pop_s) begin
            rd_ptr_q <= rd_ptr_q + (AW)'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/dmem_dump.sv
// Data-memory readback engine: sweeps a word-aligned range of data memory
// through a 1-cycle-latency read port and streams the words out on a
// valid/ready interface with a last flag.
// Optional feature macro: DMEM_DUMP_SUM_EN appends a mod-2^32 sum word
// (carrying the last flag) after the data words.
module dmem_dump
   import rv32i_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNTW       = DUMP_CNTW
) (
   input  logic            clk,
   input  logic            arst,
   input  logic            start_i,
   input  logic [ADW-1:0]  base_addr_i,
   input  logic [CNTW-1:0] word_count_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            mem_re_o,
   output logic [ADW-1:0]  mem_addr_o,
   input  logic [DPW-1:0]  mem_rdata_i,
   output logic            m_valid_o,
   input  logic            m_ready_i,
   output logic [DPW-1:0]  m_data_o,
   output logic            m_last_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int OW = CW + 1;
   localparam int FW = DPW + 1;
   localparam logic [OW-1:0]   DEPTH_O = OW'(FIFO_DEPTH);
   localparam logic [CNTW-1:0] ONE_C   = CNTW'(1);
   localparam logic [CNTW-1:0] ZERO_C  = '0;
   localparam logic [ADW-1:0]  STEP_C  = ADW'(4);

   dump_state_e     state_q;
   logic            busy_q;
   logic            done_q;
   logic            mem_re_q;
   logic            rvalid_q;     // mem_rdata_i carries a requested word this cycle
   logic [ADW-1:0]  mem_addr_q;
   logic [ADW-1:0]  next_addr_q;
   logic [CNTW-1:0] cnt_q;
   logic [CNTW-1:0] issued_q;
   logic [CNTW-1:0] ret_q;

   logic [CW-1:0]   fifo_count_s;
   logic            fifo_valid_s;
   logic [FW-1:0]   fifo_dout_s;
   logic            push_s;
   logic [FW-1:0]   push_data_s;
   logic            pop_s;
   logic            fire_last_s;
   logic            data_last_s;
   logic [OW-1:0]   occ_s;
   logic            credit_ok_s;
   logic            issue_s;

   // Credit: buffered words plus reads whose data has not yet landed must leave room.
   always_comb begin
      occ_s       = {1'b0, fifo_count_s} + {{(OW-1){1'b0}}, rvalid_q} + {{(OW-1){1'b0}}, mem_re_q};
      credit_ok_s = (occ_s < DEPTH_O);
      issue_s     = (state_q == RUN) && credit_ok_s;
   end

   assign pop_s       = fifo_valid_s && m_ready_i;
   assign fire_last_s = pop_s && fifo_dout_s[DPW];

`ifdef DMEM_DUMP_SUM_EN
   logic [DPW-1:0] sum_q;
   logic           sum_sent_q;
   logic           sum_push_s;

   assign data_last_s = 1'b0;
   assign sum_push_s  = (state_q == DRAIN) && !sum_sent_q && !rvalid_q &&
                        (ret_q == cnt_q) && (fifo_count_s != CW'(FIFO_DEPTH));

   // Running sum of returned words; the sum word is queued once after the data.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         sum_q      <= '0;
         sum_sent_q <= 1'b0;
      end else if ((state_q == IDLE) && start_i) begin
         sum_q      <= '0;
         sum_sent_q <= 1'b0;
      end else begin
         if (rvalid_q) begin
            sum_q <= sum_q + mem_rdata_i;
         end
         if (sum_push_s) begin
            sum_sent_q <= 1'b1;
         end
      end
   end
`else
   assign data_last_s = (ret_q == cnt_q - ONE_C);
`endif

   // Select what enters the buffer: returned memory data, or the sum word.
   always_comb begin
      push_s      = rvalid_q;
      push_data_s = {data_last_s, mem_rdata_i};
`ifdef DMEM_DUMP_SUM_EN
      if (sum_push_s) begin
         push_s      = 1'b1;
         push_data_s = {1'b1, sum_q};
      end else begin
         push_s      = rvalid_q;
      end
`endif
   end

   dmem_dump_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (FW)
   ) u_fifo (
      .clk         (clk),
      .arst        (arst),
      .push_i      (push_s),
      .push_data_i (push_data_s),
      .pop_i       (pop_s),
      .pop_data_o  (fifo_dout_s),
      .valid_o     (fifo_valid_s),
      .count_o     (fifo_count_s)
   );

   // Controller: accepts a start, issues reads under credit, finishes on the last handshake.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_re_q    <= 1'b0;
         rvalid_q    <= 1'b0;
         mem_addr_q  <= '0;
         next_addr_q <= '0;
         cnt_q       <= '0;
         issued_q    <= '0;
         ret_q       <= '0;
      end else begin
         mem_re_q <= 1'b0;
         rvalid_q <= mem_re_q;
         if (rvalid_q) begin
            ret_q <= ret_q + ONE_C;
         end
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               if (start_i) begin
                  busy_q   <= 1'b1;
                  cnt_q    <= word_count_i;
                  ret_q    <= '0;
                  issued_q <= '0;
                  if (word_count_i == ZERO_C) begin
                     state_q <= DRAIN;
`ifndef DMEM_DUMP_SUM_EN
                     done_q  <= 1'b1;
`endif
                  end else begin
                     mem_re_q    <= 1'b1;
                     mem_addr_q  <= dump_align(base_addr_i);
                     next_addr_q <= dump_align(base_addr_i) + STEP_C;
                     issued_q    <= ONE_C;
                     state_q     <= (word_count_i == ONE_C) ? DRAIN : RUN;
                  end
               end
            end
            RUN: begin
               if (issue_s) begin
                  mem_re_q    <= 1'b1;
                  mem_addr_q  <= next_addr_q;
                  next_addr_q <= next_addr_q + STEP_C;
                  issued_q    <= issued_q + ONE_C;
                  if (issued_q == cnt_q - ONE_C) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (done_q) begin
                  done_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (fire_last_s) begin
                  done_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign mem_re_o   = mem_re_q;
   assign mem_addr_o = mem_addr_q;
   assign m_valid_o  = fifo_valid_s;
   assign m_data_o   = fifo_dout_s[DPW-1:0];
   assign m_last_o   = fifo_dout_s[DPW];

endmodule

// File: doc/dmem_dump.md
# dmem_dump

Data-memory readback engine for the rv32i core: the read-side counterpart to the word-write preload port (`data_en`/`input_addr`/`input_data`). On a start pulse it sweeps a word-aligned address range of data memory through a 1-cycle-latency read port. It buffers the returned words and streams them out on a valid/ready interface with a last flag. It sits beside the core's data memory and feeds a debug/UART bridge or a testbench scoreboard.

## Interface
- `FIFO_DEPTH`, default 4: output buffer depth in words; power of two, ≥ 2.
- `CNTW`, default 16: width of the word-count input.
- `clk`  in  1  rising-edge clock.
- `arst`  in  1  asynchronous, active-high reset. The block has one clock; reset is asynchronous and active-high.
- `start_i`  in  1  one-cycle start request; ignored while `busy_o`=1.
- `base_addr_i`  in  ADW  start byte address; bits [1:0] forced to 0.
- `word_count_i`  in  CNTW  number of words to read.
- `busy_o`  out  1  high from the cycle after an accepted start until the `done_o` cycle, inclusive.
- `done_o`  out  1  one-cycle pulse when the final stream word is accepted.
- `mem_re_o`  out  1  memory read enable.
- `mem_addr_o`  out  ADW  memory byte address.
- `mem_rdata_i`  in  DPW  read data; valid exactly one cycle after `mem_re_o`.
- `m_valid_o`  out  1  stream word valid.
- `m_ready_i`  in  1  downstream ready.
- `m_data_o`  out  DPW  stream word.
- `m_last_o`  out  1  marks the final stream word.

## Operation
- States are `IDLE`, `RUN` and `DRAIN`.
- In `IDLE`:
  - A `start_i` pulse latches the aligned base address and the count.
  - The block moves to `RUN`, or to `DRAIN` if the count is 0.
- In `RUN`:
  - A read is issued when (FIFO occupancy + in-flight reads) < FIFO_DEPTH.
  - Read address is base + 4·i, wrapping mod 2^ADW.
  - After the final read issues, the block moves to `DRAIN`.
- In `DRAIN`: the block waits until the FIFO is empty and the last word has handshaken, then pulses `done_o` and returns to `IDLE`.
- Returned data is pushed into the FIFO the same cycle it is valid. The credit rule means the FIFO never overflows and no data is dropped.
- Stream handshake:
  - A word transfers when `m_valid_o` && `m_ready_i`.
  - `m_data_o`/`m_last_o` hold stable while `m_valid_o`=1 and `m_ready_i`=0.
  - `m_valid_o` never drops without a transfer.
- A count of 0 emits no stream words. `done_o` pulses 1 cycle after start.
- `start_i` while busy is ignored and has no side effects.
- `arst` at any time does all of the following:
  - returns the state to `IDLE` and flushes the FIFO;
  - discards in-flight reads;
  - clears all counters.
- Reset values: all outputs are 0 (`busy_o`, `done_o`, `mem_re_o`, `mem_addr_o`, `m_valid_o`, `m_data_o`, `m_last_o`).

## Timing
- Let start be sampled at edge T.
- First `mem_re_o` (addr = base) is high in cycle T+1, and its data returns in T+2.
- First `m_valid_o` is high in T+3, so start-to-first-word latency is 3 cycles.
- With `m_ready_i` held high and FIFO_DEPTH ≥ 4, throughput is one word per cycle.
- With N words and ready high, `done_o` is asserted in cycle T+N+3.
- When the final word handshakes in cycle X, `done_o` = 1 and `busy_o` = 1 in X+1; `busy_o` = 0 and new starts are accepted from X+2.
- `mem_re_o` and `mem_addr_o` are registered outputs.
- Back-pressure stalls read issue within one cycle of the FIFO credit reaching 0.

## Configuration
- `DMEM_DUMP_SUM_EN` defined:
  - After the last data word, one extra word is emitted: the mod-2^32 sum of all data words, with `m_last_o` on this word only.
  - A count of 0 emits a single word 0x0 with `m_last_o`=1.
  - `done_o` follows that word's handshake, so the done cycle shifts by one.
- Undefined: `m_last_o` goes on the Nth data word, and no sum logic is synthesized.

## Structure
- `rv32i_pkg` gains:
  - `DUMP_CNTW` (16);
  - `typedef enum logic [1:0] {IDLE, RUN, DRAIN} dump_state_e`.
- `DPW` and `ADW` are imported from `rv32i_pkg`.
- One sub-module, `dmem_dump_fifo`: a synchronous FIFO with async active-high reset, carrying {last, data} at DPW+1 bits, with count output.

## Test plan
1. Memory preloaded 0x0→5, 0x4→8, 0x8→0xC; start base 0x0, count 3, ready high → stream 5, 8, 0xC; last on 0xC; `done_o` at T+6.
2. Same range, ready toggled 1-0-0-1 → no word lost or duplicated; data stable while stalled; `mem_re_o` stops once the FIFO credit reaches 0.
3. Base 0xFFFF_FFF8, count 3 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
4. Count 0 → no `m_valid_o`; `done_o` 1 cycle after start. With SUM_EN, a single word 0x0 with last.
5. `arst` asserted mid-stream after 2 of 8 words → all outputs 0 immediately; a new start then re-reads from the new base correctly.
6. SUM_EN, words 5, 8, 0xFFFF_FFFF → sum word 0x0000_000C with last; a second `start_i` during busy is ignored.
